// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: responder side of the fetch handshake. Owns the program
// counter, the instruction RAM (with a loader write port), the one-entry read
// holding register and the instruction stage register, and flags handshake
// violations from the controller in a sticky error bit.
module instr_fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              InstrRAMenable,
    input  logic              InstrRAMread_en,
    input  logic              PCounterInccontrol_in,
    input  logic              PCounterIncb_in,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              StageRegld_str,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              rd_data_valid,
    output logic              proto_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        DATA_RDY = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              proto_err_q, proto_err_d;

    logic rd;

    assign rd = InstrRAMenable & InstrRAMread_en;

    // Loader write port; the RAM keeps its contents across reset, but reset still blocks a same-edge write
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read holding register; the non-blocking read of the old pc gives read-before-write on a same-address collision
    always_ff @(posedge clk) begin
        if (rd) begin
            rdata_q <= mem_q[pc_q];
        end
    end

    // Next-state logic for the handshake FSM, the program counter, the stage register and the sticky error flag
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        proto_err_d   = proto_err_q;

        if (PCounterInccontrol_in) begin
            pc_d = PCounterIncb_in ? branch_target : pc_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (StageRegld_str) begin
                    proto_err_d = 1'b1;
                end
                if (rd) begin
                    state_d = DATA_RDY;
                end
            end
            DATA_RDY: begin
                if (StageRegld_str) begin
                    instr_d       = rdata_q;
                    instr_valid_d = 1'b1;
                end
                if (rd && !StageRegld_str) begin
                    proto_err_d = 1'b1;
                end
                if (StageRegld_str && !rd) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset that wins over every strobe on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign pc            = pc_q;
    assign instr         = instr_q;
    assign instr_valid   = instr_valid_q;
    assign rd_data_valid = (state_q == DATA_RDY);
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed fetch handshake sequences with a
// bench-side RAM/PC model and a queue of expected read data that is pushed when
// a read is issued and popped when the stage register is loaded.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        InstrRAMenable;
    logic        InstrRAMread_en;
    logic        PCounterInccontrol_in;
    logic        PCounterIncb_in;
    logic [7:0]  branch_target;
    logic        StageRegld_str;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        instr_valid;
    logic        rd_data_valid;
    logic        proto_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] expQ [$];
    logic [15:0] mMem [256];
    logic [7:0]  mPc;
    logic [15:0] mInstr;
    logic        mValid;
    logic        mErr;
    logic [15:0] seqTable [3];

    instr_fetch_unit #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .InstrRAMenable        (InstrRAMenable),
        .InstrRAMread_en       (InstrRAMread_en),
        .PCounterInccontrol_in (PCounterInccontrol_in),
        .PCounterIncb_in       (PCounterIncb_in),
        .branch_target         (branch_target),
        .StageRegld_str        (StageRegld_str),
        .wr_en                 (wr_en),
        .wr_addr               (wr_addr),
        .wr_data               (wr_data),
        .pc                    (pc),
        .instr                 (instr),
        .instr_valid           (instr_valid),
        .rd_data_valid         (rd_data_valid),
        .proto_err             (proto_err)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counted, and reported on mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compare every DUT output against the bench model after an edge
    task automatic checkCycle(input string tag);
        checkOutput({tag, ".pc"}, 32'(pc), 32'(mPc));
        checkOutput({tag, ".rd_data_valid"}, 32'(rd_data_valid), 32'(expQ.size() != 0));
        checkOutput({tag, ".proto_err"}, 32'(proto_err), 32'(mErr));
        checkOutput({tag, ".instr_valid"}, 32'(instr_valid), 32'(mValid));
        checkOutput({tag, ".instr"}, 32'(instr), 32'(mInstr));
    endtask

    // Drive one cycle of strobes, advance the model from its pre-edge state, clock, then check
    task automatic applyStimulus(input string tag, input logic en, input logic rden, input logic ld,
                                 input logic inc, input logic incb, input logic [7:0] bt,
                                 input logic we, input logic [7:0] wa, input logic [15:0] wd);
        logic held;
        logic rd;
        InstrRAMenable        = en;
        InstrRAMread_en       = rden;
        StageRegld_str        = ld;
        PCounterInccontrol_in = inc;
        PCounterIncb_in       = incb;
        branch_target         = bt;
        wr_en                 = we;
        wr_addr               = wa;
        wr_data               = wd;

        rd   = en & rden;
        held = (expQ.size() != 0);
        if (ld) begin
            if (held) begin
                mInstr = expQ.pop_front();
                mValid = 1'b1;
            end else begin
                mErr = 1'b1;
            end
        end
        if (rd) begin
            if (held && !ld) begin
                void'(expQ.pop_front());
                mErr = 1'b1;
            end
            expQ.push_back(mMem[mPc]);
        end
        if (we) mMem[wa] = wd;
        if (inc) mPc = incb ? bt : mPc + 8'd1;

        @(posedge clk);
        #1;
        InstrRAMenable        = 1'b0;
        InstrRAMread_en       = 1'b0;
        StageRegld_str        = 1'b0;
        PCounterInccontrol_in = 1'b0;
        PCounterIncb_in       = 1'b0;
        wr_en                 = 1'b0;
        checkCycle(tag);
    endtask

    // One-cycle synchronous reset; the model drops held data but keeps RAM
    task automatic applyReset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mPc    = 8'h00;
        mInstr = 16'h0000;
        mValid = 1'b0;
        mErr   = 1'b0;
        expQ.delete();
        checkCycle(tag);
    endtask

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
        $fatal(1, "[TB] time limit reached");
    end

    // Directed sequence
    initial begin
        reset                 = 1'b0;
        InstrRAMenable        = 1'b0;
        InstrRAMread_en       = 1'b0;
        PCounterInccontrol_in = 1'b0;
        PCounterIncb_in       = 1'b0;
        branch_target         = 8'h00;
        StageRegld_str        = 1'b0;
        wr_en                 = 1'b0;
        wr_addr               = 8'h00;
        wr_data               = 16'h0000;
        for (int i = 0; i < 256; i++) mMem[i] = 16'h0000;
        seqTable[0] = 16'h1111;
        seqTable[1] = 16'h2222;
        seqTable[2] = 16'h3333;

        $display("[TB] initial reset and RAM load");
        applyReset("rst0");
        for (int i = 0; i < 256; i++) begin
            applyStimulus("load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'(i), 16'(i * 16'h0101 + 16'h0007));
        end
        applyStimulus("load0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 16'h1111);
        applyStimulus("load1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 16'h2222);
        applyStimulus("load2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 16'h3333);
        applyStimulus("load5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 16'hAAAA);
        applyStimulus("loadFF", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 16'hF0F0);

        $display("[TB] reset then steady fetch");
        applyReset("rst1");
        checkOutput("rst1.pc_zero", 32'(pc), 32'h0);
        checkOutput("rst1.valid_zero", 32'(instr_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("fetch.rd", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
            checkOutput("fetch.rdv", 32'(rd_data_valid), 32'h1);
            applyStimulus("fetch.ld", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
            checkOutput("fetch.seq", 32'(instr), 32'(seqTable[i]));
        end
        checkOutput("fetch.pc_end", 32'(pc), 32'h3);
        checkOutput("fetch.err", 32'(proto_err), 32'h0);

        $display("[TB] read_en without enable");
        applyStimulus("noen", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        checkOutput("noen.rdv", 32'(rd_data_valid), 32'h0);

        $display("[TB] branch and wrap");
        applyStimulus("br", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 16'h0000);
        checkOutput("br.pc", 32'(pc), 32'hFF);
        applyStimulus("br.rd", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        applyStimulus("wrap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 8'h00, 16'h0000);
        checkOutput("wrap.pc", 32'(pc), 32'h00);
        applyStimulus("wrap.ld", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        checkOutput("wrap.instr", 32'(instr), 32'hF0F0);

        $display("[TB] protocol errors");
        applyReset("rst2");
        applyStimulus("idle.ld", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        checkOutput("idle.err", 32'(proto_err), 32'h1);
        checkOutput("idle.instr", 32'(instr), 32'h0);
        checkOutput("idle.valid", 32'(instr_valid), 32'h0);
        applyStimulus("ovr.rd1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        applyStimulus("ovr.rd2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        applyStimulus("ovr.ld", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        checkOutput("ovr.instr", 32'(instr), 32'h2222);

        $display("[TB] back-to-back read with load");
        applyReset("rst3");
        applyStimulus("b2b.rd0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            applyStimulus("b2b.rdld", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
            checkOutput("b2b.seq", 32'(instr), 32'(seqTable[i]));
            checkOutput("b2b.rdv", 32'(rd_data_valid), 32'h1);
        end
        applyStimulus("b2b.ld", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        checkOutput("b2b.last", 32'(instr), 32'h3333);
        checkOutput("b2b.err", 32'(proto_err), 32'h0);

        $display("[TB] read/write collision");
        applyStimulus("col.br", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 8'h00, 16'h0000);
        applyStimulus("col.rdwr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 16'hBBBB);
        applyStimulus("col.ld1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        checkOutput("col.old", 32'(instr), 32'hAAAA);
        applyStimulus("col.rd2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        applyStimulus("col.ld2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        checkOutput("col.new", 32'(instr), 32'hBBBB);

        $display("[TB] reset mid-fetch");
        applyStimulus("mid.rd", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        applyReset("mid.rst");
        checkOutput("mid.rdv", 32'(rd_data_valid), 32'h0);
        checkOutput("mid.pc", 32'(pc), 32'h0);
        applyStimulus("mid.ld", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        checkOutput("mid.err", 32'(proto_err), 32'h1);
        applyStimulus("mid.rd2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        applyStimulus("mid.ld2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
        checkOutput("mid.ram", 32'(instr), 32'h1111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Responder side of the fetch handshake issued by the processor controller. It owns the program counter, the instruction RAM and the instruction stage register. It reacts to the controller's RAM-enable/read, PC-increment and stage-load strobes, and returns the fetched instruction plus status back to the controller and decode stage. It also provides a loader write port for filling instruction RAM.

## Interface
- ADDR_W, 8, PC and RAM address width; RAM depth is 2**ADDR_W
- DATA_W, 16, instruction word width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- InstrRAMenable  in  1  RAM enable from controller
- InstrRAMread_en  in  1  RAM read strobe; a read is issued only when both this and InstrRAMenable are high
- PCounterInccontrol_in  in  1  PC update strobe
- PCounterIncb_in  in  1  PC source select: 0 = pc+1, 1 = branch_target
- branch_target  in  ADDR_W  branch destination
- StageRegld_str  in  1  load stage register from held RAM data
- wr_en  in  1  loader write strobe
- wr_addr  in  ADDR_W  loader address
- wr_data  in  DATA_W  loader data
- pc  out  ADDR_W  current program counter
- instr  out  DATA_W  stage register contents
- instr_valid  out  1  stage register holds a loaded instruction
- rd_data_valid  out  1  RAM read data is held and not yet consumed
- proto_err  out  1  sticky handshake violation flag

## Operation
- Reset behaviour: pc=0, instr=0, instr_valid=0, rd_data_valid=0, proto_err=0, FSM=IDLE. RAM contents are not cleared.
- FSM states:
  - IDLE: no held read data.
  - DATA_RDY: registered read data is held and rd_data_valid=1.
- Read issue (rd = InstrRAMenable & InstrRAMread_en):
  - Captures mem[pc], using the pc value before any same-edge update, into the read register.
  - Next state is DATA_RDY.
- Load (StageRegld_str):
  - In DATA_RDY: instr <= read register, instr_valid <= 1. If rd is not also asserted, next state is IDLE.
  - In IDLE: proto_err <= 1; instr and instr_valid are unchanged.
- rd and load on the same edge in DATA_RDY: the load takes the old held data, the new read captures mem[pc], and the FSM stays in DATA_RDY.
- rd in DATA_RDY without load (overrun): the held data is overwritten and proto_err <= 1.
- InstrRAMread_en without InstrRAMenable: no operation and no error.
- PC update on PCounterInccontrol_in:
  - Selects pc+1 or branch_target according to PCounterIncb_in.
  - pc+1 is modulo 2**ADDR_W, so 2**ADDR_W-1 wraps to 0.
  - With PCounterInccontrol_in low, PCounterIncb_in is ignored.
- Loader write: on wr_en, mem[wr_addr] <= wr_data, allowed in any state.
  - Same-edge read of the same address returns the old data (read-before-write).
- proto_err clears only on reset.
- Reset asserted mid-operation: held read data is discarded, the FSM returns to IDLE, and all outputs take their reset values on that edge. Reset overrides every strobe on the same edge.

## Timing
- Read latency is 1 cycle: rd sampled at edge N gives rd_data_valid=1 after edge N, and StageRegld_str is legal from edge N+1.
- Fetch-to-instr latency is a minimum of 2 edges: the read at edge N, the load at edge N+1, and instr/instr_valid update after edge N+1.
- pc updates after the edge where PCounterInccontrol_in is sampled high; the new value is usable by a read on the next edge.
- rd_data_valid stays high indefinitely until it is consumed or reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset then steady fetch:
  - Stimulus: load mem[0..2]=16'h1111,16'h2222,16'h3333 via wr_en; reset 1 cycle; repeat {rd; load+inc} 3 times.
  - Response: instr sequence 1111, 2222, 3333; pc ends at 3; proto_err=0.
- Branch and wrap:
  - Stimulus: inc with Incb=1 and branch_target=8'hFF; read; inc with Incb=0.
  - Response: pc=FF, then pc=00; the read returns mem[FF].
- Protocol errors:
  - Stimulus: StageRegld_str while in IDLE.
  - Response: proto_err=1, instr unchanged, instr_valid=0.
  - Stimulus: two reads with no load between them.
  - Response: proto_err=1, and a later load takes the second read's data.
- Same-edge read and load:
  - Stimulus: issue back-to-back rd with StageRegld_str high on every cycle from the second read onward.
  - Response: one instruction per cycle with no proto_err.
- Read/write collision:
  - Stimulus: mem[5]=AAAA; pc=5; rd with wr_en to address 5 carrying BBBB on the same edge.
  - Response: the load yields AAAA, and the next read yields BBBB.
- Reset mid-fetch:
  - Stimulus: rd, then reset on the next edge, then StageRegld_str.
  - Response: after reset rd_data_valid=0 and pc=0; the load sets proto_err=1; RAM contents are preserved.
